par_to_serial: RTL and testbench

PAR_TO_SERIAL -- requirements
Module: par_to_serial

---
 rtl/par_to_serial.sv | 70 +++++++
 tb/tb_par_to_serial.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/par_to_serial.sv
// Byte-to-bit serializer: emits one byte MSB first every 8 clocks, filling with
// an idle byte when no data is offered and resyncing after reset with idle bytes.
module par_to_serial #(
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC,
  parameter int unsigned INIT_IDLES = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active
);

  localparam logic [3:0] InitIdles = 4'(INIT_IDLES);

  typedef enum logic [0:0] {StSync, StRun} state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] r_cnt;
  logic [7:0] r_sh;
  logic       r_active;
  logic [3:0] r_idle_cnt;
  logic [3:0] w_idle_cnt_next;
  logic       w_boundary;
  logic       w_accept;

  assign w_boundary = (r_cnt == 3'd7);
  assign ready_out  = (r_state == StRun) && w_boundary;
  assign w_accept   = w_boundary && valid_in && ready_out;
  assign data_out   = r_sh[7];
  assign active     = r_active;

  always_comb begin
    w_state_next    = r_state;
    w_idle_cnt_next = r_idle_cnt;
    unique case (r_state)
      StSync: begin
        if (w_boundary) w_idle_cnt_next = r_idle_cnt + 4'd1;
        // Enter RUN as cnt reaches 7 so ready_out covers the last idle bit.
        if (r_cnt == 3'd6 && r_idle_cnt == InitIdles) w_state_next = StRun;
      end
      StRun: w_state_next = StRun;
      default: w_state_next = StSync;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state    <= StSync;
      r_cnt      <= 3'd7;
      r_sh       <= 8'h00;
      r_active   <= 1'b0;
      r_idle_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_next;
      r_idle_cnt <= w_idle_cnt_next;
      r_cnt      <= r_cnt + 3'd1;
      if (w_boundary) begin
        r_sh     <= w_accept ? data_in : IDLE_BYTE;
        r_active <= w_accept;
      end else begin
        r_sh <= {r_sh[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_par_to_serial.sv
// Randomized and directed bench for par_to_serial; two instances (INIT_IDLES 4
// and 1) are checked cycle by cycle against a byte-timeline reference model.
module tb_par_to_serial;

  localparam logic [7:0] Idle = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out [2];
  logic       data_out  [2];
  logic       active    [2];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state: k = edges since reset release; one byte slot per instance.
  int          k = 0;
  int          init_idles [2] = '{4, 1};
  logic [7:0]  m_byte [2] = '{8'h00, 8'h00};
  int          m_pos  [2] = '{0, 0};
  logic        m_act  [2] = '{1'b0, 1'b0};
  logic        m_acc  [2] = '{1'b0, 1'b0};

  always #5 clk_32f = ~clk_32f;

  par_to_serial #(.IDLE_BYTE(Idle), .INIT_IDLES(4)) u_dut4 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out[0]),
    .data_out (data_out[0]),
    .active   (active[0])
  );

  par_to_serial #(.IDLE_BYTE(Idle), .INIT_IDLES(1)) u_dut1 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out[1]),
    .data_out (data_out[1]),
    .active   (active[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic logic model_ready(input int kk, input int i);
    return (kk >= 8 * init_idles[i]) && (kk % 8 == 0);
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic rdy_prev [2];
    @(posedge clk_32f);
    for (int i = 0; i < 2; i++) rdy_prev[i] = model_ready(k, i);
    if (reset) begin
      k = 0;
      for (int i = 0; i < 2; i++) begin
        m_byte[i] = 8'h00; m_pos[i] = 0; m_act[i] = 1'b0; m_acc[i] = 1'b0;
      end
    end else begin
      k++;
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 1'b0;
        if ((k - 1) % 8 == 0) begin
          m_acc[i]  = valid_in && rdy_prev[i];
          m_byte[i] = m_acc[i] ? data_in : Idle;
          m_act[i]  = m_acc[i];
          m_pos[i]  = 0;
        end else begin
          m_pos[i]++;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "data_out4" : "data_out1", 32'(data_out[i]), 32'(m_byte[i][7 - m_pos[i]]));
      check(i == 0 ? "active4" : "active1", 32'(active[i]), 32'(m_act[i]));
      check(i == 0 ? "ready4" : "ready1", 32'(ready_out[i]), 32'(reset ? 1'b0 : model_ready(k, i)));
    end
    @(negedge clk_32f);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  // Hold valid/data until instance 0 accepts; a blown budget counts as a failure.
  task automatic send(input logic [7:0] b);
    int n;
    data_in  = b;
    valid_in = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_acc[0] && n < 64);
    check("accept_timeout", 32'(m_acc[0]), 32'd1);
    valid_in = 1'b0;
  endtask

  initial begin
    int first_rdy [2];
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk_32f);

    // Idle stream after release and first-ready cycle of both instances.
    do_reset(3);
    first_rdy = '{-1, -1};
    for (int c = 0; c < 48; c++) begin
      step();
      for (int i = 0; i < 2; i++)
        if (ready_out[i] === 1'b1 && first_rdy[i] < 0) first_rdy[i] = k;
    end
    check("first_ready4", 32'(first_rdy[0]), 32'd32);
    check("first_ready1", 32'(first_rdy[1]), 32'd8);

    // A5 held from release, then 00/FF back to back.
    do_reset(1);
    send(8'hA5);
    check("a5_edge", 32'(k), 32'd33);
    send(8'h00);
    send(8'hFF);
    repeat (20) step();

    // One-cycle valid pulse at cnt==3 is ignored.
    do_reset(1);
    while (!(k >= 40 && (k - 1) % 8 == 3)) step();
    data_in  = 8'h3C;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (16) step();

    // Reset at cnt==4 of a data byte aborts it and resyncs.
    do_reset(1);
    send(8'h5A);
    while ((k - 1) % 8 != 4) step();
    do_reset(1);
    check("abort_data", 32'(data_out[0]), 32'd0);
    repeat (40) step();

    // Randomized traffic with rare resets; data held while a request is pending.
    for (int c = 0; c < 1500; c++) begin
      if (!valid_in || m_acc[0]) begin
        valid_in = ($urandom_range(0, 2) != 0);
        data_in  = 8'($urandom);
      end
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
